// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: packs received bytes into big-endian words,
// appends the 0x80 marker, zero fill and 64-bit bit length, hands the core
// one 16-word block at a time, then streams the 256-bit digest out MSB first.
module sha256_msg_sched #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [31:0]  core_word,
    output logic         core_word_valid,
    input  logic         core_word_ready,
    output logic         core_init,
    input  logic         core_done,
    input  logic [255:0] digest_in,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         len_err
);

    typedef enum logic [1:0] {LOAD, PAD, WAIT_CORE, DIGEST} state_t;

    state_t         state_q, state_d;
    logic [31:0]    word_q, word_d;          // word being assembled / offered to the core
    logic [1:0]     bcnt_q, bcnt_d;          // byte position inside word_q
    logic [3:0]     wcnt_q, wcnt_d;          // word position inside the block
    logic [LEN_W-1:0] byte_len_q, byte_len_d;
    logic           pend_q, pend_d;          // word_q is offered to the core
    logic           in_ready_q, in_ready_d;
    logic           core_init_q, core_init_d;
    logic           first_blk_q, first_blk_d;
    logic           msg_done_q, msg_done_d;  // last message byte has been taken
    logic           need_80_q, need_80_d;    // 0x80 marker still owed as a whole word
    logic           pad_len_q, pad_len_d;    // length words belong to the current block
    logic           pad_done_q, pad_done_d;  // length words have been handed over
    logic [255:0]   digest_q, digest_d;
    logic [4:0]     dcnt_q, dcnt_d;
    logic           out_valid_q, out_valid_d;
    logic           len_err_q, len_err_d;

    logic [63:0]    bit_len;
    logic [7:0]     mark_byte;
    logic           word_go;

    assign bit_len   = 64'(byte_len_q) << 3;
    assign mark_byte = in_last ? 8'h80 : 8'h00;
    assign word_go   = pend_q && core_word_ready;

    // Next-state logic for the whole scheduler.
    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d     = state_q;
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        wcnt_d      = wcnt_q;
        byte_len_d  = byte_len_q;
        pend_d      = pend_q;
        first_blk_d = first_blk_q;
        msg_done_d  = msg_done_q;
        need_80_d   = need_80_q;
        pad_len_d   = pad_len_q;
        pad_done_d  = pad_done_q;
        digest_d    = digest_q;
        dcnt_d      = dcnt_q;
        out_valid_d = out_valid_q;
        len_err_d   = len_err_q;

        // Word handover, shared by LOAD and PAD; the 16th word closes the block.
        if (word_go) begin
            pend_d = 1'b0;
            if (wcnt_q == 4'd15) begin
                wcnt_d      = 4'd0;
                state_d     = WAIT_CORE;
                first_blk_d = 1'b0;
                if (state_q == PAD) begin
                    if (pad_len_q) begin
                        pad_done_d = 1'b1;
                    end else if (!need_80_q) begin
                        // Marker landed too late for the length: it goes in the next block.
                        pad_len_d = 1'b1;
                    end
                end
            end else begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end

        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    byte_len_d = byte_len_q + LEN_W'(1);
                    if (&byte_len_q) begin
                        len_err_d = 1'b1;
                    end
                    case (bcnt_q)
                        2'd0:    word_d = {in_byte, mark_byte, 16'h0000};
                        2'd1:    word_d = {word_q[31:24], in_byte, mark_byte, 8'h00};
                        2'd2:    word_d = {word_q[31:16], in_byte, mark_byte};
                        default: word_d = {word_q[31:8], in_byte};
                    endcase
                    if (in_last || bcnt_q == 2'd3) begin
                        pend_d = 1'b1;
                        bcnt_d = 2'd0;
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                    if (in_last) begin
                        msg_done_d = 1'b1;
                        state_d    = PAD;
                        if (bcnt_q == 2'd3) begin
                            need_80_d = 1'b1;
                        end else begin
                            pad_len_d = (wcnt_q <= 4'd13);
                        end
                    end
                end
            end
            PAD: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                    if (need_80_q) begin
                        word_d    = 32'h8000_0000;
                        need_80_d = 1'b0;
                        pad_len_d = (wcnt_q <= 4'd13);
                    end else if (pad_len_q && wcnt_q == 4'd14) begin
                        word_d = bit_len[63:32];
                    end else if (pad_len_q && wcnt_q == 4'd15) begin
                        word_d = bit_len[31:0];
                    end else begin
                        word_d = 32'h0000_0000;
                    end
                end
            end
            WAIT_CORE: begin
                if (core_done) begin
                    if (!msg_done_q) begin
                        state_d = LOAD;
                    end else if (!pad_done_q) begin
                        state_d = PAD;
                    end else begin
                        state_d     = DIGEST;
                        digest_d    = digest_in;
                        dcnt_d      = 5'd0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DIGEST: begin
                if (out_valid_q && out_ready) begin
                    digest_d = {digest_q[247:0], 8'h00};
                    if (dcnt_q == 5'd31) begin
                        out_valid_d = 1'b0;
                        state_d     = LOAD;
                        dcnt_d      = 5'd0;
                        bcnt_d      = 2'd0;
                        wcnt_d      = 4'd0;
                        byte_len_d  = '0;
                        msg_done_d  = 1'b0;
                        pad_len_d   = 1'b0;
                        pad_done_d  = 1'b0;
                        first_blk_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 5'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        in_ready_d  = (state_d == LOAD) && !pend_d;
        core_init_d = first_blk_d && pend_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= LOAD;
            word_q      <= '0;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
            byte_len_q  <= '0;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            core_init_q <= 1'b0;
            first_blk_q <= 1'b1;
            msg_done_q  <= 1'b0;
            need_80_q   <= 1'b0;
            pad_len_q   <= 1'b0;
            pad_done_q  <= 1'b0;
            digest_q    <= '0;
            dcnt_q      <= '0;
            out_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            wcnt_q      <= wcnt_d;
            byte_len_q  <= byte_len_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            core_init_q <= core_init_d;
            first_blk_q <= first_blk_d;
            msg_done_q  <= msg_done_d;
            need_80_q   <= need_80_d;
            pad_len_q   <= pad_len_d;
            pad_done_q  <= pad_done_d;
            digest_q    <= digest_d;
            dcnt_q      <= dcnt_d;
            out_valid_q <= out_valid_d;
            len_err_q   <= len_err_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign core_word       = word_q;
    assign core_word_valid = pend_q;
    assign core_init       = core_init_q;
    assign out_byte        = digest_q[255:248];
    assign out_valid       = out_valid_q;
    assign len_err         = len_err_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: a reference padder/SHA-256 fills word and byte
// scoreboards, a behavioural core compresses the blocks it is handed.
module tb_sha256_msg_sched;

    localparam int LEN_W = 32;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [31:0] word;
        logic        init;
    } wexp_t;

    typedef struct {
        int          len;
        int          kind;        // 1: "abc..." bytes, 0: arithmetic pattern
        int          exp_blocks;
        logic [31:0] exp_w15;     // final word of the final block
    } vec_t;

    logic         clk;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [31:0]  core_word;
    logic         core_word_valid;
    logic         core_word_ready;
    logic         core_init;
    logic         core_done;
    logic [255:0] digest_in;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         len_err;

    sha256_msg_sched #(.LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .core_word      (core_word),
        .core_word_valid(core_word_valid),
        .core_word_ready(core_word_ready),
        .core_init      (core_init),
        .core_done      (core_done),
        .digest_in      (digest_in),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .len_err        (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    wexp_t        wq[$];
    logic [7:0]   bq[$];
    logic         stall_en = 1'b0;
    logic         cm_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [511:0] cm_blk;
    logic [255:0] cm_h;
    logic         cm_init;
    int           cm_cnt = 0;
    int           cm_busy = 0;
    int           words_seen = 0;
    int           blocks_seen = 0;
    logic [31:0]  last_word;
    logic [255:0] got_dig;
    logic         cw_stall = 1'b0;
    logic [31:0]  cw_hold;
    logic         ob_stall = 1'b0;
    logic [7:0]   ob_hold;
    wexp_t        w_pop;
    logic [7:0]   b_pop;

    assign core_done = cm_done | spur_done;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [7:0] msg_byte(input int i, input int len, input int kind);
        if (kind == 1) return 8'(32'h61 + i);
        return 8'(i * 13 + len + 5);
    endfunction

    // Reference padding and hashing: fills the word and byte scoreboards.
    task automatic model_msg(input int len, input int kind);
        logic [7:0]   p[$];
        logic [511:0] blk;
        logic [255:0] h;
        logic [63:0]  bl;
        wexp_t        e;
        for (int i = 0; i < len; i++) p.push_back(msg_byte(i, len, kind));
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(len) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        h = IV;
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            for (int t = 0; t < 16; t++) begin
                e.word = blk[511-32*t -: 32];
                e.init = (b == 0);
                wq.push_back(e);
            end
            h = sha_comp(h, blk);
        end
        for (int j = 0; j < 32; j++) bq.push_back(h[255-8*j -: 8]);
    endtask

    // Behavioural core and output consumer, sampled on the falling edge.
    always @(negedge clk) begin
        cm_done = 1'b0;
        if (rst) begin
            cm_cnt   = 0;
            cm_busy  = 0;
            cw_stall = 1'b0;
            ob_stall = 1'b0;
        end else begin
            if (cm_busy > 0) begin
                cm_busy--;
                if (cm_busy == 0) begin
                    cm_h      = sha_comp(cm_init ? IV : cm_h, cm_blk);
                    digest_in = cm_h;
                    cm_done   = 1'b1;
                    blocks_seen++;
                end
            end
            if (cw_stall) check("core_word_hold", 256'({core_word_valid, core_word}), 256'({1'b1, cw_hold}));
            core_word_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (core_word_valid && core_word_ready) begin
                check("word_while_busy", 256'(cm_busy), 256'(0));
                check("word_expected", 256'(wq.size() != 0), 256'(1));
                if (wq.size() != 0) begin
                    w_pop = wq.pop_front();
                    check("core_word_init", 256'({core_init, core_word}), 256'({w_pop.init, w_pop.word}));
                end
                cm_blk[511-32*cm_cnt -: 32] = core_word;
                if (cm_cnt == 0) cm_init = core_init;
                cm_cnt++;
                words_seen++;
                last_word = core_word;
                if (cm_cnt == 16) begin
                    cm_cnt  = 0;
                    cm_busy = 3 + (stall_en ? int'($urandom_range(0, 5)) : 0);
                end
            end
            cw_stall = core_word_valid && !core_word_ready;
            cw_hold  = core_word;

            if (ob_stall) check("out_byte_hold", 256'({out_valid, out_byte}), 256'({1'b1, ob_hold}));
            out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                check("byte_expected", 256'(bq.size() != 0), 256'(1));
                if (bq.size() != 0) begin
                    b_pop = bq.pop_front();
                    check("out_byte", 256'(out_byte), 256'(b_pop));
                end
                got_dig = {got_dig[247:0], out_byte};
            end
            ob_stall = out_valid && !out_ready;
            ob_hold  = out_byte;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        if (stall_en && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) check("in_ready_timeout", 256'(n), 256'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input vec_t v);
        int n = 0;
        wq.delete();
        bq.delete();
        blocks_seen = 0;
        words_seen  = 0;
        model_msg(v.len, v.kind);
        for (int i = 0; i < v.len; i++) send_byte(msg_byte(i, v.len, v.kind), i == v.len - 1);
        while ((wq.size() != 0 || bq.size() != 0 || out_valid) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", 256'(n < 20000), 256'(1));
        check("block_count", 256'(blocks_seen), 256'(v.exp_blocks));
        check("final_w15", 256'(last_word), 256'(v.exp_w15));
        check("idle_after_digest", 256'({in_ready, len_err, core_word_valid, out_valid}), 256'(4'b1000));
        if (v.kind == 1) check("abc_digest", got_dig, ABC_DIGEST);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   n;
        vecs[0] = '{3,   1, 1, 32'h0000_0018};
        vecs[1] = '{55,  0, 1, 32'h0000_01b8};
        vecs[2] = '{56,  0, 2, 32'h0000_01c0};
        vecs[3] = '{64,  0, 2, 32'h0000_0200};
        vecs[4] = '{1,   0, 1, 32'h0000_0008};
        vecs[5] = '{4,   0, 1, 32'h0000_0020};
        vecs[6] = '{119, 0, 2, 32'h0000_03b8};
        vecs[7] = '{120, 0, 3, 32'h0000_03c0};

        rst = 1'b1;
        in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        core_word_ready = 1'b0; out_ready = 1'b0; digest_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 256'({core_word_valid, out_valid, core_init, len_err, core_word, out_byte}), 256'(0));
        check("reset_in_ready", 256'(in_ready), 256'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        // A stray core_done while idle must not move the scheduler.
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        @(posedge clk); #1;
        check("stray_core_done", 256'({in_ready, core_word_valid, out_valid}), 256'(3'b100));

        stall_en = 1'b0;
        for (int i = 0; i < 8; i++) run_msg(vecs[i]);
        stall_en = 1'b1;
        for (int i = 0; i < 8; i++) run_msg(vecs[i]);

        // Abandon a message after seven words, then hash "abc" again.
        stall_en = 1'b0;
        wq.delete();
        bq.delete();
        words_seen = 0;
        model_msg(64, 0);
        for (int i = 0; i < 64 && words_seen < 7; i++) send_byte(msg_byte(i, 64, 0), 1'b0);
        n = 0;
        while (words_seen < 7 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("partial_words", 256'(words_seen), 256'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_reset_outputs", 256'({core_word_valid, out_valid, core_init, len_err, core_word, out_byte}), 256'(0));
        check("midrun_reset_in_ready", 256'(in_ready), 256'(1));
        rst = 1'b0;
        wq.delete();
        bq.delete();
        got_dig = '0;
        @(posedge clk); #1;
        run_msg(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Sits between the UART receive path and the SHA-256 compression core.
- Accepts message bytes, packs them big-endian into 32-bit words and applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit length).
- Feeds the core one 16-word block at a time and waits for the core to finish each block.
- After the final block, serialises the 256-bit digest as 32 bytes, MSB first.

Parameters:
- LEN_W, 32, width of the message byte counter; maximum message length is 2^LEN_W-1 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_byte  in  8  message byte
- in_valid  in  1  in_byte valid
- in_last  in  1  qualifies the final byte of the message (sampled with in_valid)
- in_ready  out  1  scheduler accepts a byte when in_valid & in_ready
- core_word  out  32  message-schedule word W[t], t = 0..15
- core_word_valid  out  1  core_word valid
- core_word_ready  in  1  core takes the word when valid & ready
- core_init  out  1  high with every word of the first block; core loads initial H constants
- core_done  in  1  one-cycle pulse; block compression finished, H updated
- digest_in  in  256  core H0..H7, H0 in [255:224]
- out_byte  out  8  digest byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer takes the byte when valid & ready
- len_err  out  1  sticky; message exceeded 2^LEN_W-1 bytes; cleared by rst only

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State is LOAD. Counters are cleared: bcnt (byte in word), wcnt (word in block), byte_len.
- States: LOAD, PAD, WAIT_CORE, DIGEST.
- LOAD, byte acceptance:
  - in_ready = 1 only when no word is pending.
  - Each accepted byte shifts into the word register (first byte lands in [31:24]); bcnt increments and byte_len increments.
  - On the 4th byte, the word becomes pending and core_word_valid rises on the next cycle. in_ready stays low until core_word_ready is seen.
- LOAD, last byte:
  - On acceptance with in_last = 1, the 0x80 byte is appended at the next byte position in the same word, or as byte 0 of the next word if bcnt was 3.
  - Remaining bytes of that word are zero-filled. The word is emitted; state goes to PAD.
- PAD:
  - Emits zero words until wcnt = 14, then the bit length {byte_len,3'b0} zero-extended to 64 bits: W14 = high 32 bits, W15 = low 32 bits.
  - If the 0x80 word landed at wcnt 14 or 15, the current block is zero-filled to wcnt 15. A fresh block is then started with W0..W13 = 0 and W14/W15 = length.
- Block boundary:
  - After the word at wcnt 15 is accepted, wcnt wraps to 0 and the state goes to WAIT_CORE. in_ready and core_word_valid stay low.
  - On core_done, return to LOAD if the message is incomplete, to PAD if padding is incomplete, otherwise go to DIGEST.
- core_init is 1 for every word of the first block of a message and 0 thereafter.
- DIGEST:
  - digest_in is latched in the cycle core_done is seen.
  - Bytes are emitted [255:248] first, one per out_valid & out_ready. After the 32nd handshake, return to LOAD with counters cleared.
- Handshake rules: core_word and out_byte are held stable while valid & !ready. valid is never deasserted without a handshake.
- Edge cases:
  - A core_done pulse outside WAIT_CORE is ignored.
  - A byte arriving while in_ready = 0 is not consumed.
  - byte_len wrap sets len_err; the message still completes using the wrapped length.
- rst mid-operation: returns to reset state within one cycle and abandons partial blocks and digest output. The core must be reset alongside.
- Zero-length messages are unsupported: every message has at least one byte carrying in_last.

Test Plan:
- "abc" (61,62,63, last on 63) with core model
  - Words: 61626380, 0 x13, 00000000, 00000018.
  - core_init is high on all 16 words.
  - out bytes: ba 78 16 bf ... 15 ad.
- 55-byte message: single block; W13 holds 0x80 in the last byte position; W15 = 000001B8.
- 56-byte message: two blocks.
  - Block 1: W14 = 80000000, W15 = 0.
  - Block 2: W0..W14 = 0, W15 = 000001C0.
  - core_init is low for block 2.
- 64-byte message: block 1 is pure data; block 2 has W0 = 80000000, W15 = 00000200. No words are emitted before the core_done of block 1.
- Backpressure: random core_word_ready and out_ready stalls. core_word and out_byte are stable under stall and the digest is unchanged. in_valid is held during a stall and no byte is lost.
- rst pulse at wcnt 7 of block 1, then "abc": outputs clear next cycle and the "abc" results are identical to the first scenario.
